// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM Wishbone arbiter: grant states,
// master indices and the default poison word returned on a watchdog abort.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam logic [31:0] DEFAULT_POISON_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_wb_arbiter_if.sv
// Wishbone bundle between the CPU/DMA masters, the arbiter and the SDRAM controller.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sdram_wb_arbiter_if;

  logic        cpu_stb_i, cpu_cyc_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i;
  logic        cpu_ack_o;
  logic [31:0] cpu_dat_o;

  logic        dma_stb_i, dma_cyc_i, dma_we_i;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i;
  logic        dma_ack_o;
  logic [31:0] dma_dat_o;

  logic        sdr_stb_o, sdr_cyc_o, sdr_we_o;
  logic [3:0]  sdr_sel_o;
  logic [31:0] sdr_adr_o, sdr_dat_o;
  logic        sdr_ack_i;
  logic [31:0] sdr_dat_i;

  logic [1:0]  arb_gnt_o;
  logic        arb_err_o;

  modport slave (
    input  cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output cpu_ack_o, cpu_dat_o,
    input  dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    output dma_ack_o, dma_dat_o,
    output sdr_stb_o, sdr_cyc_o, sdr_we_o, sdr_sel_o, sdr_adr_o, sdr_dat_o,
    input  sdr_ack_i, sdr_dat_i,
    output arb_gnt_o, arb_err_o
  );

  modport master (
    output cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input  cpu_ack_o, cpu_dat_o,
    output dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    input  dma_ack_o, dma_dat_o,
    input  sdr_stb_o, sdr_cyc_o, sdr_we_o, sdr_sel_o, sdr_adr_o, sdr_dat_o,
    output sdr_ack_i, sdr_dat_i,
    input  arb_gnt_o, arb_err_o
  );

endinterface

// File: rtl/sdram_arb_watchdog.sv
// Grant watchdog: counts granted cycles without a slave ack and flags expiry
// combinationally on the cycle the count reaches LIMIT-1.
module sdram_arb_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  assign expired = en && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter sharing the SDRAM controller port.
// Define SDRAM_ARB_TIMEOUT_EN to add a watchdog that aborts unacknowledged transfers.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] POISON_DATA    = DEFAULT_POISON_DATA
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  sdram_wb_arbiter_if.slave   bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e  state_q, state_d;
  logic        last_gnt_q, last_gnt_d;

  logic        req_cpu, req_dma;
  logic        granted, sel_dma;
  logic        g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_adr, g_dat;
  logic        ack_g;
  logic [31:0] dat_g;
  logic        wd_expired;

  assign req_cpu = bus.cpu_stb_i & bus.cpu_cyc_i;
  assign req_dma = bus.dma_stb_i & bus.dma_cyc_i;
  assign granted = (state_q != IDLE);
  assign sel_dma = (state_q == GNT_DMA);

  assign g_cyc = sel_dma ? bus.dma_cyc_i : bus.cpu_cyc_i;
  assign g_stb = sel_dma ? bus.dma_stb_i : bus.cpu_stb_i;
  assign g_we  = sel_dma ? bus.dma_we_i  : bus.cpu_we_i;
  assign g_sel = sel_dma ? bus.dma_sel_i : bus.cpu_sel_i;
  assign g_adr = sel_dma ? bus.dma_adr_i : bus.cpu_adr_i;
  assign g_dat = sel_dma ? bus.dma_dat_i : bus.cpu_dat_i;

`ifdef SDRAM_ARB_TIMEOUT_EN
  sdram_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .clr     (!granted),
    .en      (granted && g_cyc && !bus.sdr_ack_i),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // An abandoned transfer (cyc dropped) returns to IDLE without touching
  // last_gnt, so the aborting master keeps its turn in the round-robin order.
  always_comb begin
    state_d        = state_q;
    last_gnt_d     = last_gnt_q;
    bus.sdr_cyc_o  = 1'b0;
    bus.sdr_stb_o  = 1'b0;
    bus.sdr_we_o   = 1'b0;
    bus.sdr_sel_o  = '0;
    bus.sdr_adr_o  = '0;
    bus.sdr_dat_o  = '0;
    ack_g          = 1'b0;
    dat_g          = '0;

    case (state_q)
      IDLE: begin
        if (req_cpu && (!req_dma || last_gnt_q == M_DMA))
          state_d = GNT_CPU;
        else if (req_dma)
          state_d = GNT_DMA;
      end
      GNT_CPU, GNT_DMA: begin
        if (!wd_expired) begin
          bus.sdr_cyc_o = g_cyc;
          bus.sdr_stb_o = g_stb & g_cyc;
          bus.sdr_we_o  = g_we;
          bus.sdr_sel_o = g_sel;
          bus.sdr_adr_o = g_adr;
          bus.sdr_dat_o = g_dat;
        end
        ack_g = bus.sdr_ack_i | wd_expired;
        dat_g = wd_expired ? POISON_DATA : bus.sdr_dat_i;
        if (!g_cyc) begin
          state_d = IDLE;
        end else if (bus.sdr_ack_i || wd_expired) begin
          state_d    = IDLE;
          last_gnt_d = sel_dma ? M_DMA : M_CPU;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_ack_o = ack_g & !sel_dma;
  assign bus.dma_ack_o = ack_g &  sel_dma;
  assign bus.cpu_dat_o = sel_dma ? 32'h0 : dat_g;
  assign bus.dma_dat_o = sel_dma ? dat_g : 32'h0;
  assign bus.arb_gnt_o = {state_q == GNT_DMA, state_q == GNT_CPU};
  assign bus.arb_err_o = wd_expired;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= M_DMA;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter; covers the watchdog path
// when SDRAM_ARB_TIMEOUT_EN is defined and the held-grant path otherwise.
module tb_sdram_wb_arbiter;

  logic wb_clk_i;
  logic wb_rst_n;
  int   checks = 0;
  int   errors = 0;

  sdram_wb_arbiter_if bus ();

  sdram_wb_arbiter #(
    .TIMEOUT_CYCLES (16),
    .POISON_DATA    (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .bus      (bus)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // m selects the master: 0 drives the CPU port, 1 drives the DMA port
  task automatic applyStimulus(input logic m, input logic req, input logic we,
                               input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (!m) begin
      bus.cpu_cyc_i = req; bus.cpu_stb_i = req; bus.cpu_we_i = we;
      bus.cpu_sel_i = sel; bus.cpu_adr_i = adr; bus.cpu_dat_i = dat;
    end else begin
      bus.dma_cyc_i = req; bus.dma_stb_i = req; bus.dma_we_i = we;
      bus.dma_sel_i = sel; bus.dma_adr_i = adr; bus.dma_dat_i = dat;
    end
  endtask

  task automatic slave_respond(input logic ack, input logic [31:0] dat);
    bus.sdr_ack_i = ack;
    bus.sdr_dat_i = dat;
  endtask

  localparam logic [31:0] CPU_ADR = 32'h1000_0100;
  localparam logic [31:0] DMA_ADR = 32'h3800_0040;

  initial begin
    logic [1:0] exp_gnt [6];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    // Reset with both masters requesting and a stray slave ack
    wb_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, CPU_ADR, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, DMA_ADR, 32'h0);
    slave_respond(1'b1, 32'hFFFF_FFFF);
    repeat (3) tick();
    checkOutput("rst_gnt", 32'(bus.arb_gnt_o), 32'h0);
    checkOutput("rst_sdr_cyc", 32'(bus.sdr_cyc_o), 32'h0);
    checkOutput("rst_sdr_stb", 32'(bus.sdr_stb_o), 32'h0);
    checkOutput("rst_sdr_adr", bus.sdr_adr_o, 32'h0);
    checkOutput("rst_cpu_ack", 32'(bus.cpu_ack_o), 32'h0);
    checkOutput("rst_dma_ack", 32'(bus.dma_ack_o), 32'h0);
    checkOutput("rst_cpu_dat", bus.cpu_dat_o, 32'h0);
    checkOutput("rst_dma_dat", bus.dma_dat_o, 32'h0);
    checkOutput("rst_err", 32'(bus.arb_err_o), 32'h0);

    wb_rst_n = 1'b1;
    slave_respond(1'b0, 32'h0);
    tick();
    checkOutput("first_gnt_cpu", 32'(bus.arb_gnt_o), 32'h1);
    checkOutput("first_sdr_adr", bus.sdr_adr_o, CPU_ADR);
    checkOutput("first_sdr_stb", 32'(bus.sdr_stb_o), 32'h1);
    slave_respond(1'b1, 32'h0000_CAFE);
    settle();
    checkOutput("first_cpu_ack", 32'(bus.cpu_ack_o), 32'h1);
    checkOutput("first_cpu_dat", bus.cpu_dat_o, 32'h0000_CAFE);
    checkOutput("first_dma_dat", bus.dma_dat_o, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    slave_respond(1'b0, 32'h0);
    checkOutput("first_idle_gap", 32'(bus.arb_gnt_o), 32'h0);

    // DMA read only, slave acks after 4 cycles
    tick();
    checkOutput("dma_gnt", 32'(bus.arb_gnt_o), 32'h2);
    checkOutput("dma_sdr_adr", bus.sdr_adr_o, DMA_ADR);
    repeat (4) tick();
    checkOutput("dma_wait_ack", 32'(bus.dma_ack_o), 32'h0);
    slave_respond(1'b1, 32'h0000_1234);
    settle();
    checkOutput("dma_ack", 32'(bus.dma_ack_o), 32'h1);
    checkOutput("dma_dat", bus.dma_dat_o, 32'h0000_1234);
    checkOutput("dma_cpu_ack", 32'(bus.cpu_ack_o), 32'h0);
    tick();
    slave_respond(1'b0, 32'h0);
    checkOutput("dma_ack_single", 32'(bus.dma_ack_o), 32'h0);

    // Contention: six back-to-back transfers, 2-cycle slave latency
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, CPU_ADR, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, DMA_ADR, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rr_gnt_%0d", i), 32'(bus.arb_gnt_o), 32'(exp_gnt[i]));
      checkOutput($sformatf("rr_adr_%0d", i), bus.sdr_adr_o, exp_gnt[i][1] ? DMA_ADR : CPU_ADR);
      tick();
      slave_respond(1'b1, 32'h0000_0100 + 32'(i));
      settle();
      checkOutput($sformatf("rr_cpu_ack_%0d", i), 32'(bus.cpu_ack_o), 32'(exp_gnt[i][0]));
      checkOutput($sformatf("rr_dma_ack_%0d", i), 32'(bus.dma_ack_o), 32'(exp_gnt[i][1]));
      tick();
      slave_respond(1'b0, 32'h0);
      checkOutput($sformatf("rr_idle_%0d", i), 32'(bus.arb_gnt_o), 32'h0);
      if (i == 5) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      tick();
    end

    // CPU write arrives while DMA holds the grant
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, DMA_ADR, 32'h0);
    tick();
    checkOutput("wr_dma_gnt", 32'(bus.arb_gnt_o), 32'h2);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, CPU_ADR, 32'hA5A5_A5A5);
    tick();
    checkOutput("wr_still_dma", 32'(bus.arb_gnt_o), 32'h2);
    checkOutput("wr_dma_we", 32'(bus.sdr_we_o), 32'h0);
    slave_respond(1'b1, 32'h0);
    settle();
    checkOutput("wr_dma_ack", 32'(bus.dma_ack_o), 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    slave_respond(1'b0, 32'h0);
    checkOutput("wr_idle", 32'(bus.arb_gnt_o), 32'h0);
    tick();
    checkOutput("wr_cpu_gnt", 32'(bus.arb_gnt_o), 32'h1);
    checkOutput("wr_sdr_we", 32'(bus.sdr_we_o), 32'h1);
    checkOutput("wr_sdr_sel", 32'(bus.sdr_sel_o), 32'h3);
    checkOutput("wr_sdr_dat", bus.sdr_dat_o, 32'hA5A5_A5A5);
    checkOutput("wr_sdr_adr", bus.sdr_adr_o, CPU_ADR);
    slave_respond(1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    slave_respond(1'b0, 32'h0);

    // DMA abandons its transfer with a CPU request pending
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, DMA_ADR, 32'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, CPU_ADR, 32'h0);
    tick();
    bus.dma_cyc_i = 1'b0;
    settle();
    checkOutput("abt_sdr_cyc", 32'(bus.sdr_cyc_o), 32'h0);
    checkOutput("abt_sdr_stb", 32'(bus.sdr_stb_o), 32'h0);
    tick();
    checkOutput("abt_idle", 32'(bus.arb_gnt_o), 32'h0);
    tick();
    checkOutput("abt_cpu_next", 32'(bus.arb_gnt_o), 32'h1);
    slave_respond(1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    slave_respond(1'b0, 32'h0);

    // last_gnt is CPU; a DMA abort must leave it there so DMA wins the next tie
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, DMA_ADR, 32'h0);
    tick();
    bus.dma_cyc_i = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, CPU_ADR, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, DMA_ADR, 32'h0);
    tick();
    checkOutput("abt_rr_dma", 32'(bus.arb_gnt_o), 32'h2);
    slave_respond(1'b1, 32'h0);
    tick();
    slave_respond(1'b0, 32'h0);
    tick();
    checkOutput("wd_cpu_gnt", 32'(bus.arb_gnt_o), 32'h1);

`ifdef SDRAM_ARB_TIMEOUT_EN
    repeat (14) tick();
    checkOutput("wd_pre_ack", 32'(bus.cpu_ack_o), 32'h0);
    checkOutput("wd_pre_err", 32'(bus.arb_err_o), 32'h0);
    tick();
    checkOutput("wd_ack", 32'(bus.cpu_ack_o), 32'h1);
    checkOutput("wd_dat", bus.cpu_dat_o, 32'hDEAD_BEEF);
    checkOutput("wd_err", 32'(bus.arb_err_o), 32'h1);
    checkOutput("wd_sdr_stb", 32'(bus.sdr_stb_o), 32'h0);
    tick();
    checkOutput("wd_err_pulse", 32'(bus.arb_err_o), 32'h0);
    checkOutput("wd_idle", 32'(bus.arb_gnt_o), 32'h0);
    tick();
    checkOutput("wd_dma_next", 32'(bus.arb_gnt_o), 32'h2);
`else
    repeat (110) tick();
    checkOutput("hold_gnt", 32'(bus.arb_gnt_o), 32'h1);
    checkOutput("hold_ack", 32'(bus.cpu_ack_o), 32'h0);
    checkOutput("hold_err", 32'(bus.arb_err_o), 32'h0);
    slave_respond(1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    slave_respond(1'b0, 32'h0);
    tick();
    checkOutput("hold_dma_next", 32'(bus.arb_gnt_o), 32'h2);
`endif

    // Reset in the middle of a DMA grant; a late ack must not reach DMA
    wb_rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_gnt", 32'(bus.arb_gnt_o), 32'h0);
    slave_respond(1'b1, 32'h0000_5555);
    settle();
    checkOutput("mid_rst_ack", 32'(bus.dma_ack_o), 32'h0);
    checkOutput("mid_rst_dat", bus.dma_dat_o, 32'h0);
    wb_rst_n = 1'b1;
    slave_respond(1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
